pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Drives per-stage enable/flush and PC enable from memory-wait, load-use, redirect and halt events.
//  Owns the halt-drain FSM, a dmem-wait watchdog and a stall-cycle counter.
//  Sits beside the datapath; outputs connect straight to the pipeline register
//  EN/FLUSH controls and the PC write enable.
// PARAMETERS
//  STALL_CW     16  width of stall_cnt (wraps)
//  DWAIT_LIMIT  64  consecutive dmem-wait cycles that raise dwait_timeout
//  DWAIT_CW     8   width of watchdog counter; must hold DWAIT_LIMIT
// PORTS
//  CLK            in   1   clock, rising edge
//  RST            in   1   asynchronous reset, active-high
//  ihit           in   1   imem access completes this cycle
//  dhit           in   1   dmem access completes this cycle
//  mem_dREN       in   1   instr in MEM stage reads dmem
//  mem_dWEN       in   1   instr in MEM stage writes dmem
//  mem_halt       in   1   instr in MEM stage is halt
//  mem_redirect   in   1   taken branch/jump/jr resolved in MEM stage
//  ex_dREN        in   1   instr in EX stage is a load
//  ex_rt          in   5   load destination register in EX
//  id_rs          in   5   rs of instr in ID
//  id_rt          in   5   rt of instr in ID
//  id_uses_rt     in   1   ID instr reads rt (R-type, sw, beq/bne)
//  pc_en          out  1   PC updates this edge
//  IF_EN..MEM_EN  out  1x4 stage register latches this edge
//  IF_FLUSH..MEM_FLUSH out 1x4 stage register loads bubble this edge (overrides EN)
//  halt_out       out  1   core halted (sticky)
//  stall_cnt      out  STALL_CW  cycles with pc_en=0 while in RUN
//  dwait_timeout  out  1   dmem wait reached DWAIT_LIMIT (sticky)
// BEHAVIOUR
//  Reset (RST=1, async): state=RUN, counters 0, halt_out=0, dwait_timeout=0.
//   While RST=1 combinational outputs forced: pc_en=0, all EN=0, all FLUSH=1.
//  FSM states RUN, DRAIN, HALTED. Outputs are combinational from state and inputs.
//  dwait = (mem_dREN|mem_dWEN) & ~dhit.
//  lduse = ex_dREN & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
//  RUN, first matching row wins:
//   1 dwait: pc_en=0, all EN=0, no FLUSH (full freeze).
//   2 mem_halt: pc_en=0; IF/ID/EX FLUSH=1; MEM_EN=1. Next state DRAIN.
//   3 mem_redirect: pc_en=1 (PC takes target); IF/ID/EX FLUSH=1; MEM_EN=1.
//   4 lduse: pc_en=0, IF_EN=0 (hold), ID_FLUSH=1, EX_EN=MEM_EN=1.
//   5 ~ihit: pc_en=0, IF_FLUSH=1, ID/EX/MEM_EN=1.
//   6 else: pc_en=1, all EN=1, no FLUSH.
//  DRAIN (1 cycle): pc_en=0, IF/ID/EX/MEM FLUSH=1. Halt is committed in MEM/WB. Next state HALTED.
//  HALTED: pc_en=0, all EN=0, no FLUSH, halt_out=1. Leaves only on RST.
//  Simultaneous: dwait beats all; halt beats redirect; redirect beats lduse and ~ihit
//   (squashed instr needs no stall); lduse+~ihit -> row 4 (IF/ID held, not flushed).
//  Watchdog: increments each RUN cycle with dwait=1 (saturates at DWAIT_LIMIT);
//   clears on any cycle with dwait=0. On reaching DWAIT_LIMIT it sets dwait_timeout.
//   Pipeline behaviour is unaffected (status only).
//  stall_cnt: +1 each RUN cycle with pc_en=0; wraps 2^STALL_CW-1 -> 0.
//  ex_rt==0 never produces lduse ($zero).
// TESTING
//  Reset: RST=1 mid-stream -> pc_en=0, EN=0000, FLUSH=1111, stall_cnt=0 in same cycle.
//  Load-use: ex_dREN=1, ex_rt=5, id_rs=5 -> one cycle IF_EN=0, ID_FLUSH=1, pc_en=0; next cycle normal.
//  Dmem wait: mem_dREN=1, dhit=0 for 3 cycles -> EN=0000 3 cycles, stall_cnt+=3.
//  Watchdog: hold dwait 64 cycles -> dwait_timeout=1 on 64th and sticky after dhit=1.
//  Redirect+lduse same cycle -> pc_en=1, IF/ID/EX_FLUSH=1, no hold.
//  Halt: mem_halt=1 -> DRAIN (all FLUSH=1), then HALTED, halt_out=1, ihit toggling ignored.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard event inputs and pipeline register controls
interface pipeline_hazard_ctrl_if #(
  parameter int STALL_CW = 16
);
  // events from the datapath
  logic                ihit;
  logic                dhit;
  logic                mem_dren;
  logic                mem_dwen;
  logic                mem_halt;
  logic                mem_redirect;
  logic                ex_dren;
  logic [4:0]          ex_rt;
  logic [4:0]          id_rs;
  logic [4:0]          id_rt;
  logic                id_uses_rt;
  // controls back to the pipeline registers and PC
  logic                pc_en;
  logic                if_en;
  logic                id_en;
  logic                ex_en;
  logic                mem_en;
  logic                if_flush;
  logic                id_flush;
  logic                ex_flush;
  logic                mem_flush;
  // status
  logic                halt_out;
  logic [STALL_CW-1:0] stall_cnt;
  logic                dwait_timeout;

  modport master (
    output ihit, dhit, mem_dren, mem_dwen, mem_halt, mem_redirect,
           ex_dren, ex_rt, id_rs, id_rt, id_uses_rt,
    input  pc_en, if_en, id_en, ex_en, mem_en,
           if_flush, id_flush, ex_flush, mem_flush,
           halt_out, stall_cnt, dwait_timeout
  );

  modport slave (
    input  ihit, dhit, mem_dren, mem_dwen, mem_halt, mem_redirect,
           ex_dren, ex_rt, id_rs, id_rt, id_uses_rt,
    output pc_en, if_en, id_en, ex_en, mem_en,
           if_flush, id_flush, ex_flush, mem_flush,
           halt_out, stall_cnt, dwait_timeout
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - 5-stage pipeline stall/flush sequencer with halt drain and dmem watchdog
module pipeline_hazard_ctrl #(
  parameter int STALL_CW    = 16,
  parameter int DWAIT_LIMIT = 64,
  parameter int DWAIT_CW    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [DWAIT_CW-1:0] WD_LIMIT = DWAIT_CW'(DWAIT_LIMIT);
  localparam logic [DWAIT_CW-1:0] WD_LAST  = DWAIT_CW'(DWAIT_LIMIT - 1);

  state_t              state;
  state_t              state_nx;
  logic [DWAIT_CW-1:0] wd_cnt;
  logic                timeout_q;
  logic [STALL_CW-1:0] stall_q;
  logic                dwait;
  logic                lduse;
  logic                pc_en;
  logic [3:0]          en;     // {if, id, ex, mem}
  logic [3:0]          flush;  // {if, id, ex, mem}

  assign dwait = (bus.mem_dren | bus.mem_dwen) & ~bus.dhit;

  // $zero is never a real dependency, so ex_rt == 0 cannot stall
  assign lduse = bus.ex_dren & (bus.ex_rt != 5'd0) &
                 ((bus.ex_rt == bus.id_rs) | (bus.id_uses_rt & (bus.ex_rt == bus.id_rt)));

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nx;
  end

  // next state and per-stage controls; priority order in RUN is dwait, halt, redirect, lduse, ~ihit
  always_comb begin
    state_nx = state;
    pc_en    = 1'b0;
    en       = 4'b0000;
    flush    = 4'b0000;
    if (rst) begin
      flush = 4'b1111;
    end else begin
      case (state)
        RUN: begin
          if (dwait) begin
            en = 4'b0000;
          end else if (bus.mem_halt) begin
            flush    = 4'b1110;
            en       = 4'b0001;
            state_nx = DRAIN;
          end else if (bus.mem_redirect) begin
            pc_en = 1'b1;
            flush = 4'b1110;
            en    = 4'b0001;
          end else if (lduse) begin
            flush = 4'b0100;
            en    = 4'b0011;
          end else if (!bus.ihit) begin
            flush = 4'b1000;
            en    = 4'b0111;
          end else begin
            pc_en = 1'b1;
            en    = 4'b1111;
          end
        end
        DRAIN: begin
          flush    = 4'b1111;
          state_nx = HALTED;
        end
        HALTED: begin
          state_nx = HALTED;
        end
        default: begin
          state_nx = RUN;
        end
      endcase
    end
  end

  // stall counter: counts RUN cycles in which the PC is held; wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          stall_q <= '0;
    else if (state == RUN && !pc_en)  stall_q <= stall_q + STALL_CW'(1);
  end

  // dmem-wait watchdog: saturating run length of dwait, sticky flag once the limit is reached
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else if (!dwait) begin
      wd_cnt <= '0;
    end else if (state == RUN && wd_cnt != WD_LIMIT) begin
      wd_cnt <= wd_cnt + DWAIT_CW'(1);
      if (wd_cnt == WD_LAST) timeout_q <= 1'b1;
    end
  end

  assign bus.pc_en         = pc_en;
  assign bus.if_en         = en[3];
  assign bus.id_en         = en[2];
  assign bus.ex_en         = en[1];
  assign bus.mem_en        = en[0];
  assign bus.if_flush      = flush[3];
  assign bus.id_flush      = flush[2];
  assign bus.ex_flush      = flush[1];
  assign bus.mem_flush     = flush[0];
  assign bus.halt_out      = (state == HALTED);
  assign bus.stall_cnt     = stall_q;
  assign bus.dwait_timeout = timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed vector bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  localparam int SCW = 4;
  localparam bit T = 1'b1;
  localparam bit F = 1'b0;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [SCW-1:0] exp_stall;

  pipeline_hazard_ctrl_if #(.STALL_CW(SCW)) bus ();

  pipeline_hazard_ctrl #(.STALL_CW(SCW), .DWAIT_LIMIT(64), .DWAIT_CW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string    name;
    bit       ihit;
    bit       dhit;
    bit       mem_dren;
    bit       mem_dwen;
    bit       mem_redirect;
    bit       ex_dren;
    bit [4:0] ex_rt;
    bit [4:0] id_rs;
    bit [4:0] id_rt;
    bit       id_uses_rt;
    bit       exp_pc;
    bit [3:0] exp_en;
    bit [3:0] exp_fl;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic chk_ctl(input string nm, input bit pc, input bit [3:0] en, input bit [3:0] fl);
    chk({nm, ".pc_en"}, {31'd0, bus.pc_en}, {31'd0, pc});
    chk({nm, ".en"}, {28'd0, bus.if_en, bus.id_en, bus.ex_en, bus.mem_en}, {28'd0, en});
    chk({nm, ".flush"}, {28'd0, bus.if_flush, bus.id_flush, bus.ex_flush, bus.mem_flush}, {28'd0, fl});
  endtask

  task automatic idle_inputs();
    bus.ihit = T; bus.dhit = T; bus.mem_dren = F; bus.mem_dwen = F;
    bus.mem_halt = F; bus.mem_redirect = F; bus.ex_dren = F;
    bus.ex_rt = 5'd0; bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.id_uses_rt = F;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_stall = '0;

    //           name        ihit dhit mrd mwr redir exld ex_rt  id_rs  id_rt  uses pc  en       fl
    vecs[0]  = '{"normal",    T, T, F, F, F, F, 5'd0, 5'd0, 5'd0, F, T, 4'b1111, 4'b0000};
    vecs[1]  = '{"imiss",     F, T, F, F, F, F, 5'd0, 5'd0, 5'd0, F, F, 4'b0111, 4'b1000};
    vecs[2]  = '{"lduse_rs",  T, T, F, F, F, T, 5'd5, 5'd5, 5'd0, F, F, 4'b0011, 4'b0100};
    vecs[3]  = '{"lduse_rt",  T, T, F, F, F, T, 5'd7, 5'd1, 5'd7, T, F, 4'b0011, 4'b0100};
    vecs[4]  = '{"rt_unused", T, T, F, F, F, T, 5'd7, 5'd1, 5'd7, F, T, 4'b1111, 4'b0000};
    vecs[5]  = '{"rt_zero",   T, T, F, F, F, T, 5'd0, 5'd0, 5'd0, T, T, 4'b1111, 4'b0000};
    vecs[6]  = '{"no_load",   T, T, F, F, F, F, 5'd5, 5'd5, 5'd5, T, T, 4'b1111, 4'b0000};
    vecs[7]  = '{"redirect",  T, T, F, F, T, F, 5'd0, 5'd0, 5'd0, F, T, 4'b0001, 4'b1110};
    vecs[8]  = '{"redir_ldu", T, T, F, F, T, T, 5'd5, 5'd5, 5'd0, F, T, 4'b0001, 4'b1110};
    vecs[9]  = '{"redir_imis",F, T, F, F, T, F, 5'd0, 5'd0, 5'd0, F, T, 4'b0001, 4'b1110};
    vecs[10] = '{"ldu_imiss", F, T, F, F, F, T, 5'd5, 5'd5, 5'd0, F, F, 4'b0011, 4'b0100};
    vecs[11] = '{"dwait_rd",  T, F, T, F, F, F, 5'd0, 5'd0, 5'd0, F, F, 4'b0000, 4'b0000};
    vecs[12] = '{"dwait_wr",  F, F, F, T, T, T, 5'd5, 5'd5, 5'd0, F, F, 4'b0000, 4'b0000};
    vecs[13] = '{"dhit_rd",   T, T, T, F, F, F, 5'd0, 5'd0, 5'd0, F, T, 4'b1111, 4'b0000};
    vecs[14] = '{"nodmem",    T, F, F, F, F, F, 5'd0, 5'd0, 5'd0, F, T, 4'b1111, 4'b0000};

    // reset state
    rst = 1'b1;
    idle_inputs();
    #2;
    chk_ctl("reset", F, 4'b0000, 4'b1111);
    chk("reset.stall_cnt", {28'd0, bus.stall_cnt}, 32'd0);
    chk("reset.halt_out", {31'd0, bus.halt_out}, 32'd0);
    chk("reset.timeout", {31'd0, bus.dwait_timeout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // single-cycle RUN vectors
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      bus.ihit = vecs[i].ihit; bus.dhit = vecs[i].dhit;
      bus.mem_dren = vecs[i].mem_dren; bus.mem_dwen = vecs[i].mem_dwen;
      bus.mem_halt = F; bus.mem_redirect = vecs[i].mem_redirect;
      bus.ex_dren = vecs[i].ex_dren; bus.ex_rt = vecs[i].ex_rt;
      bus.id_rs = vecs[i].id_rs; bus.id_rt = vecs[i].id_rt; bus.id_uses_rt = vecs[i].id_uses_rt;
      #1;
      chk_ctl(vecs[i].name, vecs[i].exp_pc, vecs[i].exp_en, vecs[i].exp_fl);
      chk({vecs[i].name, ".stall_cnt"}, {28'd0, bus.stall_cnt}, {28'd0, exp_stall});
      if (!vecs[i].exp_pc) exp_stall = exp_stall + 1'b1;
    end

    // load-use stalls one cycle then the pipeline moves normally
    @(negedge clk);
    idle_inputs();
    bus.ex_dren = T; bus.ex_rt = 5'd5; bus.id_rs = 5'd5;
    #1;
    chk_ctl("lduse_seq1", F, 4'b0011, 4'b0100);
    exp_stall = exp_stall + 1'b1;
    @(negedge clk);
    idle_inputs();
    #1;
    chk_ctl("lduse_seq2", T, 4'b1111, 4'b0000);
    chk("lduse_seq.stall_cnt", {28'd0, bus.stall_cnt}, {28'd0, exp_stall});

    // three-cycle dmem wait freezes everything
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle_inputs();
      bus.mem_dren = T; bus.dhit = F;
      #1;
      chk_ctl("dwait3", F, 4'b0000, 4'b0000);
      exp_stall = exp_stall + 1'b1;
    end
    @(negedge clk);
    idle_inputs();
    #1;
    chk_ctl("dwait3_done", T, 4'b1111, 4'b0000);
    chk("dwait3.stall_cnt", {28'd0, bus.stall_cnt}, {28'd0, exp_stall});
    chk("dwait3.timeout", {31'd0, bus.dwait_timeout}, 32'd0);

    // watchdog: 63 wait cycles stay quiet, the 64th sets the sticky flag
    @(negedge clk);
    bus.mem_dwen = T; bus.dhit = F;
    repeat (63) @(posedge clk);
    @(negedge clk);
    chk("wd_63.timeout", {31'd0, bus.dwait_timeout}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("wd_64.timeout", {31'd0, bus.dwait_timeout}, 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    exp_stall = exp_stall + SCW'(67);
    chk("wd.stall_wrap", {28'd0, bus.stall_cnt}, {28'd0, exp_stall});
    bus.dhit = T;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("wd_sticky.timeout", {31'd0, bus.dwait_timeout}, 32'd1);
    chk_ctl("wd_release", T, 4'b1111, 4'b0000);

    // reset mid-stream, with a dmem wait pending on the inputs
    bus.dhit = F;
    rst = 1'b1;
    #1;
    chk_ctl("midreset", F, 4'b0000, 4'b1111);
    chk("midreset.stall_cnt", {28'd0, bus.stall_cnt}, 32'd0);
    chk("midreset.timeout", {31'd0, bus.dwait_timeout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    exp_stall = '0;

    // halt beats a simultaneous redirect, then drain, then halted
    @(negedge clk);
    bus.mem_halt = T; bus.mem_redirect = T;
    #1;
    chk_ctl("halt", F, 4'b0001, 4'b1110);
    chk("halt.halt_out", {31'd0, bus.halt_out}, 32'd0);
    exp_stall = exp_stall + 1'b1;
    @(negedge clk);
    idle_inputs();
    #1;
    chk_ctl("drain", F, 4'b0000, 4'b1111);
    chk("drain.halt_out", {31'd0, bus.halt_out}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.ihit = i[0];
      bus.ex_dren = T; bus.ex_rt = 5'd3; bus.id_rs = 5'd3;
      bus.mem_redirect = i[1];
      #1;
      chk_ctl("halted", F, 4'b0000, 4'b0000);
      chk("halted.halt_out", {31'd0, bus.halt_out}, 32'd1);
    end
    chk("halted.stall_cnt", {28'd0, bus.stall_cnt}, {28'd0, exp_stall});

    // only reset leaves HALTED
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    #1;
    chk("halt_reset.halt_out", {31'd0, bus.halt_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_ctl("after_halt_reset", T, 4'b1111, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
